// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter over 16 request lines feeding a 16-to-4 encoder.
// Holds one one-hot grant until acknowledged or abandoned after ACK_TIMEOUT.
module onehot_rr_arbiter #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req_pulse,
    input  logic        grant_ack,
    output logic [15:0] encoder_in,
    output logic        enable,
    output logic        timeout,
    output logic [7:0]  grant_count,
    output logic [15:0] pending
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] LIMIT = 8'(ACK_TIMEOUT - 1);

    state_t      state, state_n;
    logic [3:0]  last, last_n;
    logic [3:0]  cur, cur_n;
    logic [7:0]  wait_cnt, wait_n;
    logic [15:0] enc_n, pend_n;
    logic        en_n, to_n;
    logic [7:0]  cnt_n;
    logic [3:0]  pick;
    logic        found;

    // First pending line strictly after last, wrapping at 16
    always_comb begin
        pick  = 4'd0;
        found = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (!found && pending[last + 4'(i)]) begin
                found = 1'b1;
                pick  = last + 4'(i);
            end
        end
    end

    always_comb begin
        state_n = state;
        enc_n   = encoder_in;
        en_n    = enable;
        to_n    = 1'b0;
        cnt_n   = grant_count;
        last_n  = last;
        cur_n   = cur;
        wait_n  = wait_cnt;
        pend_n  = pending | req_pulse;
        case (state)
            IDLE: begin
                if (found) begin
                    enc_n   = 16'd1 << pick;
                    en_n    = 1'b1;
                    cur_n   = pick;
                    wait_n  = 8'd0;
                    state_n = GRANT;
                end else begin
                    enc_n = 16'd0;
                    en_n  = 1'b0;
                end
            end
            GRANT: begin
                if (grant_ack) begin
                    // New requests on the same edge win over the clear
                    pend_n  = (pending & ~encoder_in) | req_pulse;
                    enc_n   = 16'd0;
                    en_n    = 1'b0;
                    last_n  = cur;
                    cnt_n   = grant_count + 8'd1;
                    state_n = IDLE;
                end else if (wait_cnt == LIMIT) begin
                    enc_n   = 16'd0;
                    en_n    = 1'b0;
                    to_n    = 1'b1;
                    last_n  = cur;
                    state_n = IDLE;
                end else begin
                    wait_n = wait_cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            encoder_in  <= 16'd0;
            enable      <= 1'b0;
            timeout     <= 1'b0;
            grant_count <= 8'd0;
            pending     <= 16'd0;
            last        <= 4'hF;
            cur         <= 4'd0;
            wait_cnt    <= 8'd0;
        end else begin
            state       <= state_n;
            encoder_in  <= enc_n;
            enable      <= en_n;
            timeout     <= to_n;
            grant_count <= cnt_n;
            pending     <= pend_n;
            last        <= last_n;
            cur         <= cur_n;
            wait_cnt    <= wait_n;
        end
    end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Directed self-checking bench for onehot_rr_arbiter.
module tb_onehot_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] req_pulse;
    logic        grant_ack;
    logic [15:0] encoder_in;
    logic        enable;
    logic        timeout;
    logic [7:0]  grant_count;
    logic [15:0] pending;

    int checks = 0;
    int errors = 0;

    onehot_rr_arbiter #(.ACK_TIMEOUT(15)) dut (
        .clk(clk),
        .reset(reset),
        .req_pulse(req_pulse),
        .grant_ack(grant_ack),
        .encoder_in(encoder_in),
        .enable(enable),
        .timeout(timeout),
        .grant_count(grant_count),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_pulse = 16'h0000;
        grant_ack = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("rst_enc", encoder_in, 16'h0000);
        chk("rst_en", {15'd0, enable}, 16'd0);
        chk("rst_to", {15'd0, timeout}, 16'd0);
        chk("rst_cnt", {8'd0, grant_count}, 16'd0);
        chk("rst_pend", pending, 16'h0000);
    endtask

    task automatic test_basic;
        req_pulse = 16'h0001;
        step();
        req_pulse = 16'h0000;
        chk("basic_pend1", pending, 16'h0001);
        chk("basic_en_early", {15'd0, enable}, 16'd0);
        step();
        chk("basic_enc", encoder_in, 16'h0001);
        chk("basic_en", {15'd0, enable}, 16'd1);
        grant_ack = 1'b1;
        step();
        grant_ack = 1'b0;
        chk("basic_en_off", {15'd0, enable}, 16'd0);
        chk("basic_enc_off", encoder_in, 16'h0000);
        chk("basic_pend0", pending, 16'h0000);
        chk("basic_cnt", {8'd0, grant_count}, 16'd1);
    endtask

    task automatic test_idle_ack;
        grant_ack = 1'b1;
        step();
        step();
        grant_ack = 1'b0;
        chk("idle_ack_cnt", {8'd0, grant_count}, 16'd1);
        chk("idle_ack_en", {15'd0, enable}, 16'd0);
    endtask

    task automatic test_round_robin;
        req_pulse = 16'h8001;
        step();
        req_pulse = 16'h0000;
        chk("rr_pend", pending, 16'h8001);
        step();
        chk("rr_first", encoder_in, 16'h8000);
        grant_ack = 1'b1;
        step();
        grant_ack = 1'b0;
        chk("rr_cnt1", {8'd0, grant_count}, 16'd2);
        chk("rr_pend2", pending, 16'h0001);
        chk("rr_gap", {15'd0, enable}, 16'd0);
        step();
        chk("rr_second", encoder_in, 16'h0001);
        grant_ack = 1'b1;
        step();
        grant_ack = 1'b0;
        chk("rr_cnt2", {8'd0, grant_count}, 16'd3);
        chk("rr_pend3", pending, 16'h0000);
    endtask

    task automatic test_timeout;
        int bad = 0;
        req_pulse = 16'h0010;
        step();
        req_pulse = 16'h0000;
        step();
        chk("to_enc", encoder_in, 16'h0010);
        for (int k = 0; k < 14; k++) begin
            step();
            if (enable !== 1'b1 || timeout !== 1'b0 ||
                encoder_in !== 16'h0010)
                bad++;
        end
        chk("to_hold", 16'(bad), 16'd0);
        step();
        chk("to_en_off", {15'd0, enable}, 16'd0);
        chk("to_pulse", {15'd0, timeout}, 16'd1);
        chk("to_pend", pending, 16'h0010);
        chk("to_cnt", {8'd0, grant_count}, 16'd3);
        step();
        chk("to_pulse_end", {15'd0, timeout}, 16'd0);
        chk("to_regrant", encoder_in, 16'h0010);
        grant_ack = 1'b1;
        step();
        grant_ack = 1'b0;
        chk("to_cnt2", {8'd0, grant_count}, 16'd4);
    endtask

    task automatic test_ack_at_limit;
        req_pulse = 16'h0020;
        step();
        req_pulse = 16'h0000;
        step();
        chk("lim_enc", encoder_in, 16'h0020);
        for (int k = 0; k < 14; k++) step();
        grant_ack = 1'b1;
        step();
        grant_ack = 1'b0;
        chk("lim_to", {15'd0, timeout}, 16'd0);
        chk("lim_cnt", {8'd0, grant_count}, 16'd5);
        chk("lim_pend", pending, 16'h0000);
    endtask

    task automatic test_same_edge;
        req_pulse = 16'h0008;
        step();
        req_pulse = 16'h0000;
        step();
        chk("se_enc", encoder_in, 16'h0008);
        grant_ack = 1'b1;
        req_pulse = 16'h0008;
        step();
        grant_ack = 1'b0;
        req_pulse = 16'h0000;
        chk("se_pend", pending, 16'h0008);
        chk("se_cnt", {8'd0, grant_count}, 16'd6);
        step();
        chk("se_regrant", encoder_in, 16'h0008);
        grant_ack = 1'b1;
        step();
        grant_ack = 1'b0;
        chk("se_pend0", pending, 16'h0000);
    endtask

    task automatic test_reset_mid_grant;
        req_pulse = 16'h0400;
        step();
        req_pulse = 16'h0000;
        step();
        chk("rm_enc", encoder_in, 16'h0400);
        reset = 1'b1;
        grant_ack = 1'b1;
        req_pulse = 16'h00FF;
        step();
        reset = 1'b0;
        grant_ack = 1'b0;
        req_pulse = 16'h0000;
        chk("rm_enc0", encoder_in, 16'h0000);
        chk("rm_en0", {15'd0, enable}, 16'd0);
        chk("rm_pend0", pending, 16'h0000);
        chk("rm_cnt0", {8'd0, grant_count}, 16'd0);
    endtask

    task automatic test_wrap;
        logic [15:0] exp_enc;
        req_pulse = 16'hFFFF;
        grant_ack = 1'b1;
        for (int e = 1; e <= 513; e++) begin
            step();
            exp_enc = (e % 2 == 0) ? (16'd1 << ((e / 2 - 1) % 16)) : 16'd0;
            checks++;
            if (!$onehot0(encoder_in) || encoder_in !== exp_enc ||
                enable !== (e % 2 == 0)) begin
                errors++;
                $display("FAIL wrap_e%0d: enc %h en %b expected enc %h",
                         e, encoder_in, enable, exp_enc);
            end
            if (e == 511) chk("wrap_255", {8'd0, grant_count}, 16'd255);
        end
        req_pulse = 16'h0000;
        grant_ack = 1'b0;
        chk("wrap_cnt0", {8'd0, grant_count}, 16'd0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_idle_ack();
        test_round_robin();
        test_timeout();
        test_ack_at_limit();
        test_same_edge();
        test_reset_mid_grant();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
